// File: rtl/alu_mc.sv
// -----------------------------------------------------------------------------
// alu_mc : parametrised multi-cycle ALU with valid/ready on both sides.
//
// Operations (ALUOp): 000 AND, 001 OR, 010 ADD, 011 SUB, 100 XOR, 101 SLT,
// 110 SLL (one bit per cycle), 111 MUL (unsigned shift-add, WIDTH cycles).
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_valid   operands and opcode valid
//   in_ready   block can accept an operation (IDLE and not in reset)
//   A, B       operands, WIDTH bits
//   ALUOp      3-bit opcode
//   out_valid  Result and flags valid
//   out_ready  consumer accepts the result
//   Result     registered result, WIDTH bits
//   CarryOut   carry flag (ADD/SUB only)
//   Overflow   signed overflow (ADD/SUB) or non-zero high product half (MUL)
//   Zero       Result == 0, registered together with Result
//   dbg_state  current FSM state, for observation only
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. Input side: in_ready is high only in IDLE outside reset, and A/B/ALUOp
// are captured on the accepting edge. Output side: out_valid stays high with
// Result and flags frozen until the edge where out_ready is also high; the FSM
// then returns to IDLE, so in_ready rises one cycle later (no same-cycle
// turnaround).
// -----------------------------------------------------------------------------
module alu_mc #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       ALUOp,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Result,
   output logic             CarryOut,
   output logic             Overflow,
   output logic             Zero,
   output logic [1:0]       dbg_state
);

   // Shift-amount field width, derived from WIDTH.
   localparam int SHW = $clog2(WIDTH);
   // Iteration counter must hold WIDTH itself (MUL iteration count).
   localparam int CW  = SHW + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SLT = 3'b101;
   localparam logic [2:0] OP_SLL = 3'b110;

   logic [1:0]         state_q,  state_d;
   logic [2*WIDTH-1:0] acc_q,    acc_d;     // MUL accumulator / SLL shifter (low half)
   logic [WIDTH-1:0]   mcand_q,  mcand_d;   // MUL multiplicand
   logic [CW-1:0]      cnt_q,    cnt_d;     // remaining EXEC iterations
   logic               is_mul_q, is_mul_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               carry_q,  carry_d;
   logic               ovf_q,    ovf_d;
   logic               zero_q,   zero_d;

   // Shared adder for ADD/SUB/SLT: SUB and SLT use A + ~B + 1.
   logic               is_sub;
   logic [WIDTH-1:0]   b_eff;
   logic [WIDTH:0]     addsub;
   logic               as_ovf;

   // One iteration of the EXEC datapaths.
   logic [WIDTH:0]     mul_part;
   logic [2*WIDTH-1:0] mul_next;
   logic [2*WIDTH-1:0] sll_next;

   // Result staging: only a completing operation updates the output registers.
   logic               load;
   logic [WIDTH-1:0]   res_n;
   logic               cy_n;
   logic               ov_n;

   always_comb begin
      is_sub = (ALUOp == OP_SUB) || (ALUOp == OP_SLT);
      b_eff  = is_sub ? ~B : B;
      addsub = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
      // Signed overflow: operands share a sign that the sum does not.
      as_ovf = (A[WIDTH-1] == b_eff[WIDTH-1]) && (addsub[WIDTH-1] != A[WIDTH-1]);
   end

   always_comb begin
      // Multiplier bits sit in the low half and are consumed from bit 0; the
      // partial sum enters at the top and the whole accumulator shifts right.
      mul_part = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
               + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
      mul_next = {mul_part, acc_q[WIDTH-1:1]};
      sll_next = {{WIDTH{1'b0}}, acc_q[WIDTH-2:0], 1'b0};
   end

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      cnt_d    = cnt_q;
      is_mul_d = is_mul_q;
      result_d = result_q;
      carry_d  = carry_q;
      ovf_d    = ovf_q;
      zero_d   = zero_q;
      load     = 1'b0;
      res_n    = '0;
      cy_n     = 1'b0;
      ov_n     = 1'b0;

      case (state_q)
         S_IDLE: begin
            // in_ready is high here whenever rst is low; reset overrides below.
            if (in_valid) begin
               state_d = S_DONE;
               load    = 1'b1;
               case (ALUOp)
                  OP_AND: res_n = A & B;
                  OP_OR:  res_n = A | B;
                  OP_XOR: res_n = A ^ B;
                  OP_ADD, OP_SUB: begin
                     res_n = addsub[WIDTH-1:0];
                     cy_n  = addsub[WIDTH];
                     ov_n  = as_ovf;
                  end
                  OP_SLT: res_n = {{(WIDTH-1){1'b0}}, addsub[WIDTH-1] ^ as_ovf};
                  OP_SLL: begin
                     if (B[SHW-1:0] == '0) begin
                        res_n = A;
                     end else begin
                        load     = 1'b0;
                        state_d  = S_EXEC;
                        acc_d    = {{WIDTH{1'b0}}, A};
                        cnt_d    = {1'b0, B[SHW-1:0]};
                        is_mul_d = 1'b0;
                     end
                  end
                  default: begin // MUL
                     load     = 1'b0;
                     state_d  = S_EXEC;
                     acc_d    = {{WIDTH{1'b0}}, B};
                     mcand_d  = A;
                     cnt_d    = CW'(WIDTH);
                     is_mul_d = 1'b1;
                  end
               endcase
            end
         end
         S_EXEC: begin
            acc_d = is_mul_q ? mul_next : sll_next;
            cnt_d = cnt_q - CW'(1);
            // Last iteration: publish straight from the freshly computed value.
            if (cnt_q == CW'(1)) begin
               state_d = S_DONE;
               load    = 1'b1;
               res_n   = acc_d[WIDTH-1:0];
               ov_n    = is_mul_q && (|acc_d[2*WIDTH-1:WIDTH]);
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (load) begin
         result_d = res_n;
         carry_d  = cy_n;
         ovf_d    = ov_n;
         zero_d   = ~|res_n;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         cnt_q    <= '0;
         is_mul_q <= 1'b0;
         result_q <= '0;
         carry_q  <= 1'b0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         cnt_q    <= cnt_d;
         is_mul_q <= is_mul_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         ovf_q    <= ovf_d;
         zero_q   <= zero_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE) && !rst;
   assign out_valid = (state_q == S_DONE);
   assign Result    = result_q;
   assign CarryOut  = carry_q;
   assign Overflow  = ovf_q;
   assign Zero      = zero_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_mc.sv
// -----------------------------------------------------------------------------
// tb_alu_mc : randomized scoreboard bench for alu_mc (WIDTH = 32).
// Stimulus pushes the model's expected response at accept time; an independent
// monitor pops and compares whenever the DUT completes an output handshake.
// -----------------------------------------------------------------------------
module tb_alu_mc;

   localparam int W     = 32;
   localparam int EXP_W = W + 11; // {latency[7:0], result, carry, overflow, zero}

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  A = '0;
   logic [W-1:0]  B = '0;
   logic [2:0]    ALUOp = 3'b000;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  Result;
   logic          CarryOut;
   logic          Overflow;
   logic          Zero;
   logic [1:0]    dbg_state;

   alu_mc #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .ALUOp     (ALUOp),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Result    (Result),
      .CarryOut  (CarryOut),
      .Overflow  (Overflow),
      .Zero      (Zero),
      .dbg_state (dbg_state)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   logic [EXP_W-1:0] exp_q[$];
   int               acc_cyc_q[$];
   int               checks = 0;
   int               errors = 0;
   bit               force_rdy = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [EXP_W-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
      longint     sa = longint'($signed(a));
      longint     sb = longint'($signed(b));
      longint     s  = 0;
      logic [63:0] p = '0;
      logic [W-1:0] r = '0;
      logic       c = 1'b0;
      logic       o = 1'b0;
      int         lat = 1;
      case (op)
         3'd0: r = a & b;
         3'd1: r = a | b;
         3'd2: begin
            p = {32'b0, a} + {32'b0, b};
            r = p[W-1:0];
            c = p[W];
            s = sa + sb;
            o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         3'd3: begin
            r = a - b;
            c = (a >= b);
            s = sa - sb;
            o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         3'd4: r = a ^ b;
         3'd5: r = (sa < sb) ? 32'd1 : 32'd0;
         3'd6: begin
            r   = a << b[4:0];
            lat = (b[4:0] == 5'd0) ? 1 : int'(b[4:0]) + 1;
         end
         default: begin
            p   = 64'(a) * 64'(b);
            r   = p[W-1:0];
            o   = (p[63:32] != 32'd0);
            lat = W + 1;
         end
      endcase
      return {8'(lat), r, c, o, (r == '0)};
   endfunction

   // ---------------- driver ----------------
   task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      int n = 0;
      @(negedge clk);
      in_valid = 1'b1;
      ALUOp    = op;
      A        = a;
      B        = b;
      #1;
      while (!in_ready && n < 300) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!in_ready) begin
         chk("accept_timeout", 64'(dbg_state), 64'hFFFF);
         in_valid = 1'b0;
      end else begin
         exp_q.push_back(model(op, a, b));
         acc_cyc_q.push_back(cyc);
         @(posedge clk);
         #1;
         in_valid = 1'b0;
      end
   endtask

   task automatic do_reset(input int cycles);
      @(negedge clk);
      rst = 1'b1;
      in_valid = 1'b0;
      exp_q.delete();
      acc_cyc_q.delete();
      repeat (cycles) @(negedge clk);
      rst = 1'b0;
   endtask

   function automatic logic [W-1:0] rnd_word();
      case ($urandom_range(0, 5))
         0: return '0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 15));
         default: return 32'($urandom);
      endcase
   endfunction

   // Consumer: random backpressure unless a test takes direct control.
   always @(negedge clk) begin
      if (!force_rdy) out_ready = ($urandom_range(0, 3) != 0);
   end

   // ---------------- monitor ----------------
   initial begin
      bit           in_resp = 1'b0;
      int           first_cyc = 0;
      logic [W-1:0] h_res = '0;
      logic [2:0]   h_flg = '0;
      logic [EXP_W-1:0] e;
      int           acc_c;
      forever begin
         @(negedge clk);
         #1;
         if (rst) begin
            in_resp = 1'b0;
         end else if (out_valid) begin
            if (!in_resp) begin
               in_resp   = 1'b1;
               first_cyc = cyc;
               h_res     = Result;
               h_flg     = {CarryOut, Overflow, Zero};
            end else begin
               chk("hold_result", 64'(Result), 64'(h_res));
               chk("hold_flags", 64'({CarryOut, Overflow, Zero}), 64'(h_flg));
            end
            if (out_ready) begin
               in_resp = 1'b0;
               if (exp_q.size() == 0) begin
                  chk("unexpected_output", 64'(Result), 64'hDEAD_0000_0000);
               end else begin
                  e     = exp_q.pop_front();
                  acc_c = acc_cyc_q.pop_front();
                  chk("result",   64'(Result),   64'(e[W+2:3]));
                  chk("carry",    64'(CarryOut), 64'(e[2]));
                  chk("overflow", 64'(Overflow), 64'(e[1]));
                  chk("zero",     64'(Zero),     64'(e[0]));
                  chk("latency",  64'(first_cyc - acc_c), 64'(e[W+10:W+3]));
               end
            end
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #(60000 * 10);
      $display("FAIL watchdog actual=running required=finished (state %0d)", dbg_state);
      $fatal(1, "watchdog expired");
   end

   // ---------------- test sequence ----------------
   initial begin
      int  n;
      bit  seen;
      // Reset state, checked while rst is still asserted.
      repeat (3) @(negedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready",  64'(in_ready),  64'd0);
      chk("rst_result",    64'(Result),    64'd0);
      chk("rst_flags",     64'({CarryOut, Overflow, Zero}), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", 64'(in_ready), 64'd1);

      // Directed arithmetic corners.
      issue(3'd2, 32'hFFFF_FFFF, 32'd1);
      issue(3'd3, 32'h8000_0000, 32'd1);
      issue(3'd5, 32'hFFFF_FFFF, 32'd0);
      issue(3'd7, 32'h0001_0000, 32'h0001_0000);
      issue(3'd7, 32'd7, 32'd6);
      issue(3'd6, 32'd1, 32'd31);
      issue(3'd6, 32'd5, 32'd0);

      // Backpressure on an XOR result.
      n = 0;
      while ((exp_q.size() != 0) && n < 500) begin @(negedge clk); n++; end
      @(negedge clk);
      force_rdy = 1'b1;
      out_ready = 1'b0;
      issue(3'd4, 32'hA5A5_0F0F, 32'h0FF0_FFFF);
      n = 0;
      #1;
      while (!out_valid && n < 50) begin @(negedge clk); #1; n++; end
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         ALUOp    = 3'd2;
         A        = 32'd3;
         B        = 32'd4;
         #1;
         chk("bp_in_ready", 64'(in_ready), 64'd0);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      #1;
      chk("bp_release_out_valid", 64'(out_valid), 64'd0);
      chk("bp_release_in_ready",  64'(in_ready),  64'd1);
      repeat (3) @(negedge clk);
      #1;
      chk("bp_no_extra_accept", 64'(out_valid), 64'd0);
      force_rdy = 1'b0;

      // Reset in the middle of a MUL.
      issue(3'd7, 32'h1234_5678, 32'h9ABC_DEF0);
      repeat (9) @(negedge clk);
      do_reset(1);
      #1;
      chk("abort_out_valid", 64'(out_valid), 64'd0);
      chk("abort_outputs",   64'({Result, CarryOut, Overflow, Zero}), 64'd0);
      chk("abort_in_ready",  64'(in_ready), 64'd1);
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         #1;
         if (out_valid) seen = 1'b1;
      end
      chk("abort_no_result", 64'(seen), 64'd0);
      issue(3'd0, 32'hF0F0_F0F0, 32'hFF00_FF00);

      // Randomized traffic.
      for (int i = 0; i < 120; i++) begin
         issue(3'($urandom_range(0, 7)), rnd_word(), rnd_word());
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 4)) @(negedge clk);
         end
      end

      // Drain.
      n = 0;
      while ((exp_q.size() != 0) && n < 3000) begin @(negedge clk); n++; end
      chk("drain_pending", 64'(exp_q.size()), 64'd0);
      repeat (2) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
